// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- 8N1 UART transmitter with optional even parity (8E1).
//
// Sends one byte per request, LSB first: start bit (0), 8 data bits,
// optional even-parity bit, stop bit (1). Each bit lasts CLKS_PER_BIT clocks.
// A request arriving while a frame is in progress is dropped and recorded
// in the sticky o_overrun flag.
//
// Build option:
//   UART_TX_PARITY_EN  when defined, an even-parity bit (XOR of the 8 data
//                      bits) is sent between the data bits and the stop bit.
//
// Parameters:
//   CLKS_PER_BIT  clocks per serial bit (>= 2), default 868 (100 MHz/115200)
//
// Ports:
//   clk        in   clock, all registers update on the rising edge
//   i_reset    in   synchronous active-high reset
//   i_start    in   one-cycle frame request
//   i_data     in   [7:0] byte to send, sampled only in the accepted cycle
//   o_tx       out  serial line, idle high (registered)
//   o_busy     out  high while a frame is in progress (registered)
//   o_done     out  one-cycle pulse in the last cycle of the stop bit
//   o_overrun  out  sticky, set when a request is dropped; cleared by reset
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_overrun
);

    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  BAUD_ONE  = CW'(1);
    localparam logic [CW-1:0]  BAUD_ZERO = CW'(0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t          state_r, state_s;
    logic [CW-1:0]   baud_r,  baud_s;
    logic [2:0]      idx_r,   idx_s;
    logic [7:0]      shift_r, shift_s;
    logic            baud_end_s;
    logic            tx_s;
    logic            busy_s;
    logic            done_s;
    logic            overrun_s;
`ifdef UART_TX_PARITY_EN
    logic            parity_r, parity_s;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic parity_even(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    assign baud_end_s = (baud_r == BAUD_LAST);

    // Next-state, baud/index counters and shift register update.
    always_comb begin
        state_s  = state_r;
        baud_s   = baud_r;
        idx_s    = idx_r;
        shift_s  = shift_r;
`ifdef UART_TX_PARITY_EN
        parity_s = parity_r;
`endif
        case (state_r)
            IDLE: begin
                if (i_start) begin
                    state_s  = START;
                    baud_s   = BAUD_ZERO;
                    idx_s    = 3'd0;
                    shift_s  = i_data;
`ifdef UART_TX_PARITY_EN
                    // Parity captured at accept time; the shift register
                    // is consumed while the data bits go out.
                    parity_s = parity_even(i_data);
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (baud_end_s) begin
                    state_s = DATA;
                    baud_s  = BAUD_ZERO;
                end else begin
                    baud_s  = baud_r + BAUD_ONE;
                end
            end
            DATA: begin
                if (baud_end_s) begin
                    baud_s  = BAUD_ZERO;
                    shift_s = {1'b0, shift_r[7:1]};
                    if (idx_r == 3'd7) begin
                        idx_s   = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_s = PARITY;
`else
                        state_s = STOP;
`endif
                    end else begin
                        idx_s   = idx_r + 3'd1;
                    end
                end else begin
                    baud_s  = baud_r + BAUD_ONE;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_end_s) begin
                    state_s = STOP;
                    baud_s  = BAUD_ZERO;
                end else begin
                    baud_s  = baud_r + BAUD_ONE;
                end
            end
`endif
            STOP: begin
                if (baud_end_s) begin
                    state_s = IDLE;
                    baud_s  = BAUD_ZERO;
                end else begin
                    baud_s  = baud_r + BAUD_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                baud_s  = BAUD_ZERO;
                idx_s   = 3'd0;
                shift_s = 8'h00;
            end
        endcase
    end

    // Output values decoded from the next state so the outputs can be
    // registered without adding a cycle of latency.
    always_comb begin
        tx_s = 1'b1;
        case (state_s)
            IDLE:    tx_s = 1'b1;
            START:   tx_s = 1'b0;
            DATA:    tx_s = shift_s[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_s = parity_s;
`endif
            STOP:    tx_s = 1'b1;
            default: tx_s = 1'b1;
        endcase
        busy_s    = (state_s != IDLE);
        done_s    = (state_s == STOP) && (baud_s == BAUD_LAST);
        // Any request while a frame is running (o_done cycle included)
        // is dropped and latched here.
        overrun_s = o_overrun | (i_start & (state_r != IDLE));
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_r   <= IDLE;
            baud_r    <= BAUD_ZERO;
            idx_r     <= 3'd0;
            shift_r   <= 8'h00;
`ifdef UART_TX_PARITY_EN
            parity_r  <= 1'b0;
`endif
            o_tx      <= 1'b1;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            state_r   <= state_s;
            baud_r    <= baud_s;
            idx_r     <= idx_s;
            shift_r   <= shift_s;
`ifdef UART_TX_PARITY_EN
            parity_r  <= parity_s;
`endif
            o_tx      <= tx_s;
            o_busy    <= busy_s;
            o_done    <= done_s;
            o_overrun <= overrun_s;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx -- directed self-checking bench for uart_tx.
// One instance with CLKS_PER_BIT=4 for the functional cases, one instance
// with the default CLKS_PER_BIT for the 115200-baud timing case.
// Honours UART_TX_PARITY_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_uart_tx;

    localparam int CPB     = 4;
    localparam int DEF_CPB = 868;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS   = 11;
`else
    localparam int NBITS   = 10;
`endif
    localparam int FRAME     = NBITS * CPB;
    localparam int DEF_FRAME = NBITS * DEF_CPB;

    logic       clk = 1'b0;
    logic       i_reset;
    logic       i_start;
    logic [7:0] i_data;
    logic       o_tx, o_busy, o_done, o_overrun;
    logic       d_start;
    logic [7:0] d_data;
    logic       d_tx, d_busy, d_done, d_overrun;

    int   n_cmp = 0;
    int   n_err = 0;
    logic exp_ovr;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(CPB)) u_dut (
        .clk       (clk),
        .i_reset   (i_reset),
        .i_start   (i_start),
        .i_data    (i_data),
        .o_tx      (o_tx),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_overrun (o_overrun)
    );

    uart_tx u_dut_def (
        .clk       (clk),
        .i_reset   (i_reset),
        .i_start   (d_start),
        .i_data    (d_data),
        .o_tx      (d_tx),
        .o_busy    (d_busy),
        .o_done    (d_done),
        .o_overrun (d_overrun)
    );

    // Single comparison point: counts and reports mismatches.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample point is 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line level for frame bit k (0 = start bit).
    function automatic logic frame_bit(input logic [7:0] d, input int k);
        if (k == 0)      return 1'b0;
        else if (k <= 8) return d[k-1];
`ifdef UART_TX_PARITY_EN
        else if (k == 9) return ^d;
`endif
        else             return 1'b1;
    endfunction

    // Called in cycle 1 after acceptance; checks every cycle of the frame
    // and the first idle cycle after it. Optionally scrambles i_data.
    task automatic run_frame(input logic [7:0] d, input bit scramble, input string tag);
        logic s;
        for (int c = 1; c <= FRAME; c++) begin
            check_eq({tag, "_tx"},   {31'd0, o_tx},      {31'd0, frame_bit(d, (c - 1) / CPB)});
            check_eq({tag, "_busy"}, {31'd0, o_busy},    32'd1);
            check_eq({tag, "_done"}, {31'd0, o_done},    {31'd0, (c == FRAME)});
            check_eq({tag, "_ovr"},  {31'd0, o_overrun}, {31'd0, exp_ovr});
            if (scramble) i_data = 8'($urandom);
            s = i_start;
            tick();
            if (s) exp_ovr = 1'b1;
        end
        check_eq({tag, "_idle_tx"},   {31'd0, o_tx},      32'd1);
        check_eq({tag, "_idle_busy"}, {31'd0, o_busy},    32'd0);
        check_eq({tag, "_idle_done"}, {31'd0, o_done},    32'd0);
        check_eq({tag, "_idle_ovr"},  {31'd0, o_overrun}, {31'd0, exp_ovr});
    endtask

    initial begin
        int lo;
        int n;
        int done_at;

        i_reset = 1'b1;
        i_start = 1'b0;
        i_data  = 8'h00;
        d_start = 1'b0;
        d_data  = 8'h00;
        exp_ovr = 1'b0;

        // Reset state, with a request held during reset.
        i_start = 1'b1;
        tick();
        tick();
        check_eq("rst_tx",   {31'd0, o_tx},      32'd1);
        check_eq("rst_busy", {31'd0, o_busy},    32'd0);
        check_eq("rst_done", {31'd0, o_done},    32'd0);
        check_eq("rst_ovr",  {31'd0, o_overrun}, 32'd0);
        check_eq("rst_def_tx",   {31'd0, d_tx},   32'd1);
        check_eq("rst_def_busy", {31'd0, d_busy}, 32'd0);
        i_start = 1'b0;
        i_reset = 1'b0;
        tick();
        check_eq("post_rst_busy", {31'd0, o_busy}, 32'd0);

        // Basic frame 0x41: 0,1,0,0,0,0,0,1,0,(p=0),1.
        i_start = 1'b1; i_data = 8'h41;
        tick();
        i_start = 1'b0; i_data = 8'h00;
        run_frame(8'h41, 1'b0, "f41");
        tick();

        // 0x07: odd number of ones, parity bit 1 when enabled.
        i_start = 1'b1; i_data = 8'h07;
        tick();
        i_start = 1'b0;
        run_frame(8'h07, 1'b0, "f07");
        tick();

        // Back-to-back with i_start held high: one idle cycle between frames.
        i_start = 1'b1; i_data = 8'h55;
        tick();
        run_frame(8'h55, 1'b0, "b2b1");
        tick();
        i_start = 1'b0;
        run_frame(8'h55, 1'b0, "b2b2");
        check_eq("b2b_ovr_sticky", {31'd0, o_overrun}, 32'd1);
        tick();

        // Mid-frame reset during data bit 3 of 0x3C (bit 3 = 1).
        i_start = 1'b1; i_data = 8'h3C;
        tick();
        i_start = 1'b0;
        for (int k = 1; k < 18; k++) tick();
        check_eq("mid_bit3_tx",   {31'd0, o_tx},   32'd1);
        check_eq("mid_bit3_busy", {31'd0, o_busy}, 32'd1);
        i_reset = 1'b1; i_start = 1'b1;
        tick();
        exp_ovr = 1'b0;
        check_eq("mid_rst_tx",   {31'd0, o_tx},      32'd1);
        check_eq("mid_rst_busy", {31'd0, o_busy},    32'd0);
        check_eq("mid_rst_done", {31'd0, o_done},    32'd0);
        check_eq("mid_rst_ovr",  {31'd0, o_overrun}, 32'd0);
        tick();
        check_eq("mid_rst_hold_busy", {31'd0, o_busy},    32'd0);
        check_eq("mid_rst_hold_ovr",  {31'd0, o_overrun}, 32'd0);
        i_reset = 1'b0; i_data = 8'h96;
        tick();
        i_start = 1'b0;
        run_frame(8'h96, 1'b0, "after_rst");
        tick();

        // Data stability: i_data scrambled every cycle after acceptance.
        i_start = 1'b1; i_data = 8'hA5;
        tick();
        i_start = 1'b0;
        run_frame(8'hA5, 1'b1, "stab");

        // Default CLKS_PER_BIT, byte 0xFF.
        d_start = 1'b1; d_data = 8'hFF;
        tick();
        d_start = 1'b0; d_data = 8'h00;
        lo = 0;
        while (d_tx === 1'b0 && lo < 2000) begin
            lo++;
            tick();
        end
        check_eq("def_start_len", lo, 32'd868);
        n = lo;
        done_at = 0;
        while (d_busy === 1'b1 && n < 20000) begin
            n++;
            if (d_done === 1'b1) done_at = n;
            tick();
        end
        check_eq("def_frame_len", n,       DEF_FRAME);
        check_eq("def_done_at",   done_at, DEF_FRAME);
        check_eq("def_idle_tx",   {31'd0, d_tx},      32'd1);
        check_eq("def_ovr",       {31'd0, d_overrun}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
